// File: rtl/mem_arbiter64.sv
// rtl/mem_arbiter64.sv - two-port Memoria64 arbiter/sequencer; MEM_ARB_RR_EN selects round-robin over fixed priority
module mem_arbiter64 #(
  parameter int RD_LAT = 1,
  parameter int AW     = 64,
  parameter int DW     = 64
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          req_p0,
  input  logic          we_p0,
  input  logic [AW-1:0] addr_p0,
  input  logic [DW-1:0] wdata_p0,
  output logic          done_p0,
  output logic [DW-1:0] rdata_p0,
  input  logic          req_p1,
  input  logic          we_p1,
  input  logic [AW-1:0] addr_p1,
  input  logic [DW-1:0] wdata_p1,
  output logic          done_p1,
  output logic [DW-1:0] rdata_p1,
  output logic          busy,
  output logic [AW-1:0] mem_raddress,
  output logic [AW-1:0] mem_waddress,
  output logic [DW-1:0] mem_Datain,
  output logic          mem_Wr,
  input  logic [DW-1:0] mem_Dataout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // A read spends RD_LAT cycles in ACCESS; the counter runs RD_LAT-1 .. 0.
  localparam logic [3:0] CNT_INIT = 4'(RD_LAT - 1);

  state_t        state_q;
  state_t        state_d;

  // Transaction latched when leaving IDLE; win_q: 0 = port 0, 1 = port 1.
  logic          win_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [3:0]    cnt_q;
  logic [DW-1:0] rdata0_q;
  logic [DW-1:0] rdata1_q;

  logic          any_req;
  logic          start;
  logic          rd_last;
  logic          grant;
  logic          grant_we;
  logic [AW-1:0] grant_addr;
  logic [DW-1:0] grant_wdata;

  assign any_req = req_p0 | req_p1;
  assign start   = (state_q == IDLE) && any_req;
  assign rd_last = (state_q == ACCESS) && !we_q && (cnt_q == 4'd0);

`ifdef MEM_ARB_RR_EN
  // 0 = port 0 was served last, 1 = port 1 was served last.
  logic last_q;

  // On contention the port not served last wins; a lone requester always wins.
  assign grant = (req_p0 && req_p1) ? ~last_q : req_p1;

  // Record the winner as the transaction enters ACCESS.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      last_q <= 1'b0;
    end else if (start) begin
      last_q <= grant;
    end
  end
`else
  // Fixed priority: port 1 is granted only when port 0 is not requesting.
  assign grant = ~req_p0;
`endif

  assign grant_we    = grant ? we_p1    : we_p0;
  assign grant_addr  = grant ? addr_p1  : addr_p0;
  assign grant_wdata = grant ? wdata_p1 : wdata_p0;

  // Memory address/data come straight from the latched request so they
  // only move when a new transaction starts and hold otherwise.
  assign mem_raddress = addr_q;
  assign mem_waddress = addr_q;
  assign mem_Datain   = wdata_q;
  assign rdata_p0     = rdata0_q;
  assign rdata_p1     = rdata1_q;

  // State register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and state-decoded outputs; mem_Wr is decoded from state so
  // an asynchronous reset removes it immediately.
  always_comb begin
    state_d = state_q;
    busy    = 1'b1;
    done_p0 = 1'b0;
    done_p1 = 1'b0;
    mem_Wr  = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (any_req) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        mem_Wr = we_q;
        if (we_q || (cnt_q == 4'd0)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_p0 = ~win_q;
        done_p1 = win_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Latch the granted request, run the read latency counter, capture read data.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      win_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= 4'd0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (start) begin
        win_q   <= grant;
        we_q    <= grant_we;
        addr_q  <= grant_addr;
        wdata_q <= grant_wdata;
        if (!grant_we) begin
          cnt_q <= CNT_INIT;
        end
      end
      if ((state_q == ACCESS) && !we_q && (cnt_q != 4'd0)) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (rd_last) begin
        if (win_q) begin
          rdata1_q <= mem_Dataout;
        end else begin
          rdata0_q <= mem_Dataout;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter64.sv
// tb/tb_mem_arbiter64.sv - scoreboard bench for mem_arbiter64 at RD_LAT=1 (dut0) and RD_LAT=3 (dut1)
module tb_mem_arbiter64;

  logic        clk;
  logic        rst_n;
  logic        req   [2][2];
  logic        we    [2][2];
  logic [63:0] addr  [2][2];
  logic [63:0] wdata [2][2];
  logic        done  [2][2];
  logic [63:0] rdata [2][2];
  logic        busy      [2];
  logic [63:0] mem_raddr [2];
  logic [63:0] mem_waddr [2];
  logic [63:0] mem_din   [2];
  logic        mem_wr    [2];
  logic [63:0] mem_dout  [2];

  localparam logic [63:0] V_ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] V_20   = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] V_30   = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] V_BAD  = 64'h5555_5555_5555_5555;
  localparam logic [63:0] V_W0   = 64'h1111_2222_3333_4444;
  localparam logic [63:0] V_W1   = 64'h9999_8888_7777_6666;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int wr_cnt   [2];
  int done_cnt [2];
  logic [63:0] wr_addr [2];

  typedef struct {
    int          inst;
    int          port;
    logic        we;
    logic [63:0] rdata;
    int          cyc;
  } exp_t;
  exp_t sbq[$];

  mem_arbiter64 #(.RD_LAT(1)) dut0 (
    .Clk(clk), .Reset_n(rst_n),
    .req_p0(req[0][0]), .we_p0(we[0][0]), .addr_p0(addr[0][0]), .wdata_p0(wdata[0][0]),
    .done_p0(done[0][0]), .rdata_p0(rdata[0][0]),
    .req_p1(req[0][1]), .we_p1(we[0][1]), .addr_p1(addr[0][1]), .wdata_p1(wdata[0][1]),
    .done_p1(done[0][1]), .rdata_p1(rdata[0][1]),
    .busy(busy[0]), .mem_raddress(mem_raddr[0]), .mem_waddress(mem_waddr[0]),
    .mem_Datain(mem_din[0]), .mem_Wr(mem_wr[0]), .mem_Dataout(mem_dout[0])
  );

  mem_arbiter64 #(.RD_LAT(3)) dut1 (
    .Clk(clk), .Reset_n(rst_n),
    .req_p0(req[1][0]), .we_p0(we[1][0]), .addr_p0(addr[1][0]), .wdata_p0(wdata[1][0]),
    .done_p0(done[1][0]), .rdata_p0(rdata[1][0]),
    .req_p1(req[1][1]), .we_p1(we[1][1]), .addr_p1(addr[1][1]), .wdata_p1(wdata[1][1]),
    .done_p1(done[1][1]), .rdata_p1(rdata[1][1]),
    .busy(busy[1]), .mem_raddress(mem_raddr[1]), .mem_waddress(mem_waddr[1]),
    .mem_Datain(mem_din[1]), .mem_Wr(mem_wr[1]), .mem_Dataout(mem_dout[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory models: dut0 reads combinationally (latency 1), dut1 sees the
  // read address through two register stages (latency 3).
  logic [63:0] mem [2][256];
  logic [63:0] raddr_d1 = '0;
  logic [63:0] raddr_d2 = '0;
  logic        preloaded = 1'b0;

  always @(posedge clk) begin
    if (!preloaded) begin
      for (int i = 0; i < 2; i++) begin
        for (int a = 0; a < 256; a++) mem[i][a] <= '0;
        mem[i][8'h20] <= V_20;
        mem[i][8'h30] <= V_30;
      end
      preloaded <= 1'b1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (mem_wr[i]) mem[i][mem_waddr[i][7:0]] <= mem_din[i];
      end
    end
    raddr_d1 <= mem_raddr[1];
    raddr_d2 <= raddr_d1;
  end

  always_comb begin
    mem_dout[0] = mem[0][mem_raddr[0][7:0]];
    mem_dout[1] = mem[1][raddr_d2[7:0]];
  end

  task automatic check(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push(input int i, input int p, input logic w, input logic [63:0] rd, input int c);
    exp_t e;
    e.inst = i; e.port = p; e.we = w; e.rdata = rd; e.cyc = c;
    sbq.push_back(e);
  endtask

  // Requester: holds req through n completions, drops it at the edge ending the last DONE.
  task automatic drive(input int i, input int p, input logic w, input logic [63:0] a,
                       input logic [63:0] d, input int n);
    bit seen;
    we[i][p] = w; addr[i][p] = a; wdata[i][p] = d; req[i][p] = 1'b1;
    for (int k = 0; k < n; k++) begin
      seen = 1'b0;
      for (int t = 0; t < 60 && !seen; t++) begin
        @(negedge clk);
        if (done[i][p]) seen = 1'b1;
      end
      if (!seen) check("done_timeout", 1'b0, 64'(k), 64'(n));
    end
    @(posedge clk);
    #1;
    req[i][p] = 1'b0;
  endtask

  task automatic sync(output int c);
    @(posedge clk);
    #1;
    c = cyc;
  endtask

  // Monitor: every done pulse pops the next expectation and is compared.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (mem_wr[i]) begin
        wr_cnt[i]++;
        wr_addr[i] = mem_waddr[i];
      end
      if (done[i][0] && done[i][1]) check("dual_done", 1'b0, 64'(i), 64'(0));
      for (int p = 0; p < 2; p++) begin
        if (done[i][p]) begin
          done_cnt[i]++;
          if (sbq.size() == 0) begin
            check("unexpected_done", 1'b0, 64'(i * 2 + p), 64'(0));
          end else begin
            e = sbq.pop_front();
            check("done_port", (e.inst == i) && (e.port == p), 64'(i * 2 + p), 64'(e.inst * 2 + e.port));
            check("done_cycle", cyc == e.cyc, 64'(cyc), 64'(e.cyc));
            if (!e.we) check("rdata", rdata[i][p] == e.rdata, rdata[i][p], e.rdata);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int m;
    int w0;
    int d0;
    bit seen;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wr_cnt[i] = 0; done_cnt[i] = 0; wr_addr[i] = '0;
      for (int p = 0; p < 2; p++) begin
        req[i][p] = 1'b0; we[i][p] = 1'b0; addr[i][p] = '0; wdata[i][p] = '0;
      end
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_busy", busy[i] == 1'b0, 64'(busy[i]), 64'(0));
      check("rst_wr", mem_wr[i] == 1'b0, 64'(mem_wr[i]), 64'(0));
      check("rst_done", (done[i][0] | done[i][1]) == 1'b0, 64'(done[i][0] | done[i][1]), 64'(0));
      check("rst_rdata", (rdata[i][0] | rdata[i][1]) == '0, rdata[i][0] | rdata[i][1], 64'(0));
      check("rst_mem_out", (mem_raddr[i] | mem_waddr[i] | mem_din[i]) == '0,
            mem_raddr[i] | mem_waddr[i] | mem_din[i], 64'(0));
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Write then read on port 0, RD_LAT=1.
    sync(m);
    w0 = wr_cnt[0];
    push(0, 0, 1'b1, '0, m + 2);
    drive(0, 0, 1'b1, 64'h10, V_ONES, 1);
    check("wr_strobe_cycles", (wr_cnt[0] - w0) == 1, 64'(wr_cnt[0] - w0), 64'(1));
    check("wr_address", wr_addr[0] == 64'h10, wr_addr[0], 64'h10);
    check("wr_mem_content", mem[0][8'h10] == V_ONES, mem[0][8'h10], V_ONES);
    sync(m);
    push(0, 0, 1'b0, V_ONES, m + 2);
    drive(0, 0, 1'b0, 64'h10, '0, 1);

    // RD_LAT=3: port 0 reads 0x30, then port 1 reads 0x20.
    sync(m);
    push(1, 0, 1'b0, V_30, m + 4);
    drive(1, 0, 1'b0, 64'h30, '0, 1);
    sync(m);
    push(1, 1, 1'b0, V_20, m + 4);
    drive(1, 1, 1'b0, 64'h20, '0, 1);
    check("rdata_p0_kept", rdata[1][0] == V_30, rdata[1][0], V_30);

    // Simultaneous reads on dut0 (port 0 served last).
    sync(m);
`ifdef MEM_ARB_RR_EN
    push(0, 1, 1'b0, V_20, m + 2);
    push(0, 0, 1'b0, V_ONES, m + 5);
`else
    push(0, 0, 1'b0, V_ONES, m + 2);
    push(0, 1, 1'b0, V_20, m + 5);
`endif
    fork
      drive(0, 0, 1'b0, 64'h10, '0, 1);
      drive(0, 1, 1'b0, 64'h20, '0, 1);
    join

    // Back-to-back writes on dut1 (port 1 served last): p0 holds for 3, p1 for 2.
    sync(m);
`ifdef MEM_ARB_RR_EN
    push(1, 0, 1'b1, '0, m + 2);
    push(1, 1, 1'b1, '0, m + 5);
    push(1, 0, 1'b1, '0, m + 8);
    push(1, 1, 1'b1, '0, m + 11);
    push(1, 0, 1'b1, '0, m + 14);
`else
    push(1, 0, 1'b1, '0, m + 2);
    push(1, 0, 1'b1, '0, m + 5);
    push(1, 0, 1'b1, '0, m + 8);
    push(1, 1, 1'b1, '0, m + 11);
    push(1, 1, 1'b1, '0, m + 14);
`endif
    fork
      drive(1, 0, 1'b1, 64'h40, V_W0, 3);
      drive(1, 1, 1'b1, 64'h48, V_W1, 2);
    join
    check("wr_keeps_rdata_p0", rdata[1][0] == V_30, rdata[1][0], V_30);
    check("wr_keeps_rdata_p1", rdata[1][1] == V_20, rdata[1][1], V_20);
    check("b2b_mem_40", mem[1][8'h40] == V_W0, mem[1][8'h40], V_W0);
    check("b2b_mem_48", mem[1][8'h48] == V_W1, mem[1][8'h48], V_W1);

    // Reset during a write ACCESS on dut0.
    sync(m);
    d0 = done_cnt[0];
    we[0][0] = 1'b1; addr[0][0] = 64'h30; wdata[0][0] = V_BAD; req[0][0] = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 10 && !seen; t++) begin
      @(negedge clk);
      if (mem_wr[0]) seen = 1'b1;
    end
    check("abort_wr_seen", seen, 64'(seen), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_wr_drop", mem_wr[0] == 1'b0, 64'(mem_wr[0]), 64'(0));
    check("abort_busy", busy[0] == 1'b0, 64'(busy[0]), 64'(0));
    check("abort_rdata", rdata[0][0] == '0, rdata[0][0], 64'(0));
    check("abort_mem_out", (mem_waddr[0] | mem_din[0]) == '0, mem_waddr[0] | mem_din[0], 64'(0));
    req[0][0] = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt[0] == d0, 64'(done_cnt[0]), 64'(d0));
    check("abort_mem_kept", mem[0][8'h30] == V_30, mem[0][8'h30], V_30);

    // Normal service after reset release.
    sync(m);
    push(0, 0, 1'b0, V_30, m + 2);
    drive(0, 0, 1'b0, 64'h30, '0, 1);

    repeat (3) @(posedge clk);
    check("scoreboard_empty", sbq.size() == 0, 64'(sbq.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
